quant_write_back: RTL and testbench

QUANT_WRITE_BACK -- requirements
Module: quant_write_back

---
 rtl/quant_write_back.sv | 106 ++++++++++
 tb/tb_quant_write_back.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/quant_write_back.sv
// quant_write_back: buffers one quantized row and writes it to SRAM as WPR words, one per cycle.
// Define WB_ADDR_WRAP_EN to wrap the write address to 0 after ADDR_LIMIT-1.
module quant_write_back #(
   parameter int ARRAY_SIZE        = 16,
   parameter int OUTPUT_DATA_WIDTH = 24,
   parameter int WORD_ELEMS        = 4,
   parameter int ADDR_WIDTH        = 10,
   parameter int ADDR_LIMIT        = 1024
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [ADDR_WIDTH-1:0]                     base_addr,
   input  logic [15:0]                               num_rows,
   input  logic                                      in_valid,
   input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   in_data,
   output logic                                      in_ready,
   output logic                                      sram_wen_n,
   output logic [ADDR_WIDTH-1:0]                     sram_waddr,
   output logic [WORD_ELEMS*OUTPUT_DATA_WIDTH-1:0]   sram_wdata,
   output logic                                      busy,
   output logic                                      done
);
   localparam int WPR = ARRAY_SIZE / WORD_ELEMS;
   localparam int WW  = WORD_ELEMS * OUTPUT_DATA_WIDTH;
   localparam int CW  = WPR > 1 ? $clog2(WPR) : 1;
   localparam logic [CW-1:0] LAST = CW'(WPR - 1);
`ifdef WB_ADDR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(ADDR_LIMIT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

   state_t                                  state;
   logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] row;
   logic [CW-1:0]                           word_cnt;
   logic [CW-1:0]                           cnt_nx;
   logic [15:0]                             rows_left;
   logic [ADDR_WIDTH-1:0]                   addr;
   logic [ADDR_WIDTH-1:0]                   addr_nx;
   logic                                    accept;

   // addr always holds the address of the next word to be written
   assign addr_nx = (WRAP && addr == ADDR_TOP) ? '0 : addr + ADDR_WIDTH'(1);
   assign cnt_nx  = word_cnt + CW'(1);
   // in_ready is only ever high in WAIT or on the last word of a non-final row
   assign accept  = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         word_cnt   <= '0;
         rows_left  <= '0;
         addr       <= '0;
         in_ready   <= 1'b0;
         sram_wen_n <= 1'b1;
         sram_waddr <= '0;
         sram_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (accept) begin
         row        <= in_data;
         word_cnt   <= '0;
         state      <= WRITE;
         sram_wen_n <= 1'b0;
         sram_waddr <= addr;
         sram_wdata <= in_data[WW-1:0];
         addr       <= addr_nx;
         if (state == WRITE) rows_left <= rows_left - 16'd1;
         in_ready   <= WPR == 1 && (state == WAIT ? rows_left > 16'd1 : rows_left > 16'd2);
      end else begin
         case (state)
            IDLE: if (start) begin
               addr      <= base_addr;
               rows_left <= num_rows;
               busy      <= 1'b1;
               state     <= num_rows == 16'd0 ? DONE : WAIT;
               in_ready  <= num_rows != 16'd0;
               done      <= num_rows == 16'd0;
            end
            WAIT: ;
            WRITE: if (word_cnt != LAST) begin
               word_cnt   <= cnt_nx;
               sram_waddr <= addr;
               sram_wdata <= row[cnt_nx*WW +: WW];
               addr       <= addr_nx;
               in_ready   <= cnt_nx == LAST && rows_left > 16'd1;
            end else begin
               rows_left  <= rows_left - 16'd1;
               sram_wen_n <= 1'b1;
               state      <= rows_left == 16'd1 ? DONE : WAIT;
               done       <= rows_left == 16'd1;
               in_ready   <= rows_left != 16'd1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_quant_write_back.sv
// tb_quant_write_back: directed vectors for quant_write_back with hand-derived expectations.
module tb_quant_write_back;
   localparam int AS = 16, DW = 24, WE = 4, AW = 10;

   logic           clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [15:0]    num_rows = '0;
   logic [AS*DW-1:0] in_data = '0;
   logic           in_ready, sram_wen_n, busy, done;
   logic [AW-1:0]  sram_waddr;
   logic [WE*DW-1:0] sram_wdata;
   int             nvec = 0, nerr = 0;
   int             exp5 [4];

   always #5 clk = ~clk;

   quant_write_back #(
      .ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(DW), .WORD_ELEMS(WE), .ADDR_WIDTH(AW), .ADDR_LIMIT(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .sram_wen_n(sram_wen_n),
      .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // element i of a row is b+i
   function automatic logic [AS*DW-1:0] mkrow(input int b);
      logic [AS*DW-1:0] r;
      for (int i = 0; i < AS; i++) r[i*DW +: DW] = DW'(b + i);
      return r;
   endfunction

   function automatic logic [WE*DW-1:0] wordof(input int b, input int k);
      logic [WE*DW-1:0] w;
      for (int j = 0; j < WE; j++) w[j*DW +: DW] = DW'(b + WE*k + j);
      return w;
   endfunction

   task automatic go(input int base, input int n);
      base_addr = AW'(base);
      num_rows  = 16'(n);
      start     = 1'b1;
      tick;
      start     = 1'b0;
   endtask

   task automatic chk_word(input string tag, input int a, input int b, input int k, input logic rdy);
      chk({tag, " wen_n"}, sram_wen_n, 1'b0);
      chk({tag, " addr"}, sram_waddr, AW'(a));
      chk({tag, " data"}, sram_wdata, wordof(b, k));
      chk({tag, " rdy"}, in_ready, rdy);
   endtask

   task automatic chk_done(input string tag);
      chk({tag, " done"}, done, 1'b1);
      chk({tag, " done wen_n"}, sram_wen_n, 1'b1);
      chk({tag, " done rdy"}, in_ready, 1'b0);
      tick;
      chk({tag, " done low"}, done, 1'b0);
      chk({tag, " idle busy"}, busy, 1'b0);
   endtask

   initial begin
`ifdef WB_ADDR_WRAP_EN
      exp5 = '{6, 7, 0, 1};
`else
      exp5 = '{6, 7, 8, 9};
`endif
      tick;
      tick;
      chk("rst rdy", in_ready, 1'b0);
      chk("rst wen_n", sram_wen_n, 1'b1);
      chk("rst addr", sram_waddr, '0);
      chk("rst data", sram_wdata, '0);
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      rst = 1'b0;
      tick;

      // single row, elements 0..15
      go(16'h010, 1);
      chk("t1 wait busy", busy, 1'b1);
      chk("t1 wait rdy", in_ready, 1'b1);
      chk("t1 wait wen_n", sram_wen_n, 1'b1);
      in_valid = 1'b1;
      in_data  = mkrow(0);
      tick;
      in_valid = 1'b0;
      chk("t1 word0 literal", sram_wdata, 96'h000003_000002_000001_000000);
      for (int k = 0; k < 4; k++) begin
         chk_word("t1", 'h10 + k, 0, k, 1'b0);
         tick;
      end
      chk_done("t1");

      // three rows back to back, in_valid held high
      go(16'h100, 3);
      in_valid = 1'b1;
      in_data  = mkrow(100);
      tick;
      for (int c = 0; c < 12; c++) begin
         chk_word("t2", 'h100 + c, 100 * (c / 4 + 1), c % 4, (c % 4 == 3) && (c / 4 < 2));
         if (c % 4 == 0) in_data = mkrow(100 * (c / 4 + 2));
         tick;
      end
      in_valid = 1'b0;
      chk_done("t2");

      // second row arrives late
      go(16'h020, 2);
      in_valid = 1'b1;
      in_data  = mkrow(200);
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_word("t3a", 'h20 + k, 200, k, k == 3);
         tick;
      end
      for (int g = 0; g < 5; g++) begin
         chk("t3 gap wen_n", sram_wen_n, 1'b1);
         chk("t3 gap rdy", in_ready, 1'b1);
         chk("t3 gap busy", busy, 1'b1);
         if (g == 4) begin
            in_valid = 1'b1;
            in_data  = mkrow(300);
         end
         tick;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_word("t3b", 'h24 + k, 300, k, 1'b0);
         tick;
      end
      chk_done("t3");

      // empty job; start while busy is ignored
      go(16'h050, 0);
      chk("t4 done", done, 1'b1);
      chk("t4 busy", busy, 1'b1);
      chk("t4 wen_n", sram_wen_n, 1'b1);
      start    = 1'b1;
      num_rows = 16'd5;
      tick;
      start = 1'b0;
      chk("t4 done low", done, 1'b0);
      chk("t4 busy low", busy, 1'b0);
      chk("t4 rdy", in_ready, 1'b0);
      tick;
      chk("t4 still idle", busy, 1'b0);

      // address wrap behaviour around 8
      go(6, 1);
      in_valid = 1'b1;
      in_data  = mkrow(500);
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_word("t5", exp5[k], 500, k, 1'b0);
         tick;
      end
      chk_done("t5");

      // asynchronous reset during word 2, then a fresh job
      go(16'h030, 2);
      in_valid = 1'b1;
      in_data  = mkrow(600);
      tick;
      in_valid = 1'b0;
      chk_word("t6", 'h30, 600, 0, 1'b0);
      tick;
      chk_word("t6", 'h31, 600, 1, 1'b0);
      tick;
      chk_word("t6", 'h32, 600, 2, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t6 rst rdy", in_ready, 1'b0);
      chk("t6 rst wen_n", sram_wen_n, 1'b1);
      chk("t6 rst addr", sram_waddr, '0);
      chk("t6 rst data", sram_wdata, '0);
      chk("t6 rst busy", busy, 1'b0);
      chk("t6 rst done", done, 1'b0);
      tick;
      tick;
      rst = 1'b0;
      tick;
      go(16'h040, 1);
      in_valid = 1'b1;
      in_data  = mkrow(700);
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_word("t6b", 'h40 + k, 700, k, 1'b0);
         tick;
      end
      chk_done("t6b");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
